rx_uart_cfg: RTL

//  Configurable UART receiver with a first-word-fall-through (FWFT) receive FIFO.

---
 rtl/rx_uart_cfg.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rx_uart_cfg.sv
// Configurable UART receiver (5..9 data bits, optional parity, 1/2 stop bits)
// feeding a first-word-fall-through FIFO with per-word error flags.
module rx_uart_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int LOG2_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 x16BaudStrobe,
  input  logic                 serialIn,
  input  logic                 read,
  input  logic                 clearOverrun,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 parityErr,
  output logic                 frameErr,
  output logic                 dataPresent,
  output logic                 halfFull,
  output logic                 full,
  output logic                 overrun,
  output logic                 breakDetect
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;
  localparam int WORD  = DATA_BITS + 2;
  localparam logic [LOG2_DEPTH:0] HALF_CNT = (LOG2_DEPTH + 1)'(DEPTH / 2);
  localparam logic [LOG2_DEPTH:0] FULL_CNT = {1'b1, {LOG2_DEPTH{1'b0}}};
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_BRK   = 3'd5;

  logic [SYNC_STAGES-1:0] syncReg;
  logic                   rxs;
  logic [2:0]             state;
  logic [3:0]             phase;
  logic [3:0]             bitCnt;
  logic                   stopCnt;
  logic [DATA_BITS-1:0]   shiftReg;
  logic                   perr;
  logic                   ferr;
  logic                   parBit;

  logic sampleNow;
  logic ferrNext;
  logic lastStop;
  logic isBreak;
  logic push;

  logic [WORD-1:0]       mem [DEPTH];
  logic [WORD-1:0]       head;
  logic [LOG2_DEPTH:0]   wrPtr;
  logic [LOG2_DEPTH:0]   rdPtr;
  logic [LOG2_DEPTH:0]   wrNext;
  logic [LOG2_DEPTH:0]   rdNext;
  logic [LOG2_DEPTH:0]   countNext;
  logic                  fifoEmpty;
  logic                  fifoFull;
  logic                  doRead;
  logic                  doWrite;
  logic                  dropWord;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) syncReg <= '1;
    else       syncReg <= {syncReg[SYNC_STAGES-2:0], serialIn};
  end

  assign rxs = syncReg[SYNC_STAGES-1];

  // Mid-bit sample happens once per 16 strobes in every frame-receiving state.
  assign sampleNow = x16BaudStrobe && (phase == 4'd7) &&
                     (state != ST_IDLE) && (state != ST_BRK);
  assign ferrNext  = ferr | ~rxs;
  assign lastStop  = sampleNow && (state == ST_STOP) && (stopCnt == LAST_STOP);
  assign isBreak   = (shiftReg == '0) && ((PARITY == 0) || !parBit) && ferrNext;
  assign push      = lastStop && !isBreak;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= ST_IDLE;
      phase       <= 4'd0;
      bitCnt      <= 4'd0;
      stopCnt     <= 1'b0;
      shiftReg    <= '0;
      perr        <= 1'b0;
      ferr        <= 1'b0;
      parBit      <= 1'b0;
      breakDetect <= 1'b0;
    end else begin
      breakDetect <= 1'b0;
      if (x16BaudStrobe && state != ST_IDLE) phase <= phase + 4'd1;
      case (state)
        ST_IDLE: if (x16BaudStrobe && !rxs) begin
          phase <= 4'd0;
          state <= ST_START;
        end
        ST_START: if (sampleNow) begin
          if (rxs) begin
            state <= ST_IDLE;
          end else begin
            state   <= ST_DATA;
            bitCnt  <= 4'd0;
            stopCnt <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            parBit  <= 1'b0;
          end
        end
        ST_DATA: if (sampleNow) begin
          shiftReg <= {rxs, shiftReg[DATA_BITS-1:1]};
          bitCnt   <= bitCnt + 4'd1;
          if (bitCnt == LAST_BIT) state <= (PARITY != 0) ? ST_PAR : ST_STOP;
        end
        ST_PAR: if (sampleNow) begin
          parBit <= rxs;
          perr   <= ((^shiftReg) ^ rxs) != (PARITY == 1);
          state  <= ST_STOP;
        end
        ST_STOP: if (sampleNow) begin
          ferr    <= ferrNext;
          stopCnt <= stopCnt + 1'b1;
          // Leaving from mid-stop lets the next start edge resync the bit timing.
          if (lastStop) begin
            if (isBreak) begin
              breakDetect <= 1'b1;
              state       <= ST_BRK;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_BRK: if (x16BaudStrobe && rxs) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = ((wrPtr ^ rdPtr) == FULL_CNT);
  assign doRead    = read && !fifoEmpty;
  assign doWrite   = push && (!fifoFull || doRead);
  assign dropWord  = push && fifoFull && !doRead;
  assign wrNext    = wrPtr + {{LOG2_DEPTH{1'b0}}, doWrite};
  assign rdNext    = rdPtr + {{LOG2_DEPTH{1'b0}}, doRead};
  assign countNext = wrNext - rdNext;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      halfFull <= 1'b0;
      full     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      wrPtr    <= wrNext;
      rdPtr    <= rdNext;
      halfFull <= (countNext >= HALF_CNT);
      full     <= (countNext == FULL_CNT);
      if (dropWord)          overrun <= 1'b1;
      else if (clearOverrun) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr[LOG2_DEPTH-1:0]] <= {ferrNext, perr, shiftReg};
  end

  // Head is gated so an empty FIFO (including right after reset) reads as zero.
  assign head        = mem[rdPtr[LOG2_DEPTH-1:0]];
  assign dataPresent = !fifoEmpty;
  assign dataOut     = dataPresent ? head[DATA_BITS-1:0] : '0;
  assign parityErr   = dataPresent & head[DATA_BITS];
  assign frameErr    = dataPresent & head[DATA_BITS+1];

endmodule
